// File: rtl/vga_lane_renderer.sv
// Two-stage VGA pixel renderer for the rhythm game: falling-note lanes, hit bars
// with flash, score bars and a blinking win/draw screen, with sync delay matching.
module vga_lane_renderer #(
  parameter int unsigned NUM_LANES        = 2,
  parameter int unsigned WIN_W            = 3,
  parameter int unsigned H_ACTIVE         = 1280,
  parameter int unsigned V_ACTIVE         = 720,
  parameter int unsigned LANE_X0          = 170,
  parameter int unsigned LANE_PITCH       = 640,
  parameter int unsigned LANE_W           = 300,
  parameter int unsigned HIT_Y0           = 620,
  parameter int unsigned HIT_Y1           = 650,
  parameter int unsigned RES_X0           = 75,
  parameter int unsigned RES_PITCH        = 1110,
  parameter int unsigned RES_W            = 20,
  parameter logic [47:0] LANE_RGB         = 48'hFF0_00F_0F0_F00,
  parameter logic [11:0] DRAW_RGB         = 12'hFF0,
  parameter logic [11:0] HIT_RGB          = 12'h00F,
  parameter logic [11:0] FLASH_RGB        = 12'hFFF,
  parameter int unsigned HIT_FLASH_FRAMES = 6,
  parameter int unsigned BLINK_FRAMES     = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_en,
  input  logic [10:0]             x,
  input  logic [9:0]              y,
  input  logic                    active,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic [WIN_W-1:0]        winner,
  input  logic [NUM_LANES*10-1:0] block_top,
  input  logic [NUM_LANES*10-1:0] block_bot,
  input  logic [NUM_LANES*10-1:0] res_top,
  input  logic [NUM_LANES-1:0]    hit_pulse,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic                    hsync_out,
  output logic                    vsync_out
);

  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic                          fs;
  logic [10:0]                   s1_x;
  logic [9:0]                    s1_y;
  logic                          s1_active;
  logic                          s1_hsync;
  logic                          s1_vsync;
  logic [WIN_W-1:0]              sh_winner;
  logic [NUM_LANES*10-1:0]       sh_block_top;
  logic [NUM_LANES*10-1:0]       sh_block_bot;
  logic [NUM_LANES*10-1:0]       sh_res_top;
  logic [NUM_LANES-1:0]          pending;
  logic [NUM_LANES-1:0][7:0]     flash_cnt;
  logic [BLINK_W-1:0]            blink_cnt;
  logic                          blink_on;
  logic [11:0]                   pix_rgb;
  logic [11:0]                   win_rgb;
  logic [11:0]                   x12;
  logic [10:0]                   y11;

  always_comb begin
    fs = pix_en && (x == 11'd0) && (y == 10'd0);
  end

  // Stage 1 pixel/sync capture and stage 2 registered colour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_x      <= '0;
      s1_y      <= '0;
      s1_active <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else if (pix_en) begin
      s1_x      <= x;
      s1_y      <= y;
      s1_active <= active;
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
      red       <= pix_rgb[11:8];
      green     <= pix_rgb[7:4];
      blue      <= pix_rgb[3:0];
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
    end
  end

  // Per-frame shadow copies so the picture never tears mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_winner    <= '0;
      sh_block_top <= '0;
      sh_block_bot <= '0;
      sh_res_top   <= '0;
    end else if (fs) begin
      sh_winner    <= winner;
      sh_block_top <= block_top;
      sh_block_bot <= block_bot;
      sh_res_top   <= res_top;
    end
  end

  // Pulses are latched on any clock; a pulse on the frame-start edge survives to the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      flash_cnt <= '0;
    end else begin
      pending <= hit_pulse | (pending & ~{NUM_LANES{fs}});
      if (fs) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (pending[i]) begin
            flash_cnt[i] <= 8'(HIT_FLASH_FRAMES);
          end else if (flash_cnt[i] != 8'd0) begin
            flash_cnt[i] <= flash_cnt[i] - 8'd1;
          end
        end
      end
    end
  end

  // Win-screen blink phase, restarted ON whenever a game result first appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (fs) begin
      if (winner == '0 || sh_winner == '0 || BLINK_FRAMES == 0) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Colour for the stage-1 pixel; later assignments override, giving block > hit bar > score bar and lower lane first.
  always_comb begin
    pix_rgb = '0;
    win_rgb = DRAW_RGB;
    x12     = {1'b0, s1_x};
    y11     = {1'b0, s1_y};
    for (int i = 0; i < NUM_LANES; i++) begin
      if (sh_winner == WIN_W'(i + 1)) win_rgb = LANE_RGB[i*12 +: 12];
    end
    if (!s1_active) begin
      pix_rgb = '0;
    end else if (sh_winner != '0) begin
      pix_rgb = blink_on ? win_rgb : 12'h000;
    end else begin
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (x12 >= 12'(RES_X0 + i*RES_PITCH) && x12 < 12'(RES_X0 + i*RES_PITCH + RES_W) &&
            y11 >= {1'b0, sh_res_top[i*10 +: 10]} && y11 < 11'(V_ACTIVE))
          pix_rgb = LANE_RGB[i*12 +: 12];
      end
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if ((LANE_X0 + i*LANE_PITCH) < H_ACTIVE &&
            x12 >= 12'(LANE_X0 + i*LANE_PITCH) && x12 < 12'(LANE_X0 + i*LANE_PITCH + LANE_W) &&
            y11 >= 11'(HIT_Y0) && y11 < 11'(HIT_Y1))
          pix_rgb = (flash_cnt[i] != 8'd0) ? FLASH_RGB : HIT_RGB;
      end
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if ((LANE_X0 + i*LANE_PITCH) < H_ACTIVE &&
            x12 >= 12'(LANE_X0 + i*LANE_PITCH) && x12 < 12'(LANE_X0 + i*LANE_PITCH + LANE_W) &&
            y11 >= {1'b0, sh_block_top[i*10 +: 10]} && y11 < {1'b0, sh_block_bot[i*10 +: 10]})
          pix_rgb = LANE_RGB[i*12 +: 12];
      end
    end
  end

endmodule

// File: doc/vga_lane_renderer.md
Name: vga_lane_renderer

Overview:
Registered, parametrised pixel renderer for the rhythm game that draws NUM_LANES falling-note lanes, per-lane hit bars with hit flash, per-player score bars, and a blinking win/draw screen. It sits between the VGA timing generator and the RGB/sync output pins. It delays hsync/vsync to match its pipeline. All per-frame inputs are sampled once per frame so the picture does not tear.

Parameters:
NUM_LANES, 2, number of lanes/players (1..4)
WIN_W, 3, width of winner input
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 720, active lines
LANE_X0, 170, left x of lane 0
LANE_PITCH, 640, x distance between lane left edges
LANE_W, 300, lane width in pixels
HIT_Y0, 620, hit bar top (inclusive)
HIT_Y1, 650, hit bar bottom (exclusive)
RES_X0, 75, left x of score bar 0
RES_PITCH, 1110, x distance between score bars
RES_W, 20, score bar width
LANE_RGB, {12'hF00,12'h0F0,12'h00F,12'hFF0}, packed 12-bit RGB per lane, lane 0 in the LSBs
DRAW_RGB, 12'hFF0, draw-screen colour
HIT_RGB, 12'h00F, idle hit bar colour
FLASH_RGB, 12'hFFF, flashing hit bar colour
HIT_FLASH_FRAMES, 6, frames a hit bar stays flashed (1..255)
BLINK_FRAMES, 30, frames per win-screen on/off phase; 0 = no blink

Ports:
clk  in  1  pixel-domain clock
rst  in  1  asynchronous active-high reset
pix_en  in  1  pixel tick; pipeline advances only when high
x  in  11  current pixel column
y  in  10  current pixel row
active  in  1  pixel is in the visible area
hsync_in  in  1  horizontal sync from the timing generator
vsync_in  in  1  vertical sync from the timing generator
winner  in  WIN_W  0 = playing; 1..NUM_LANES = that player won; >NUM_LANES = draw
block_top  in  NUM_LANES*10  per-lane note block top y
block_bot  in  NUM_LANES*10  per-lane note block bottom y (exclusive)
res_top  in  NUM_LANES*10  per-player score bar top y
hit_pulse  in  NUM_LANES  one-clk pulse per lane on a successful hit
red  out  4  pixel red
green  out  4  pixel green
blue  out  4  pixel blue
hsync_out  out  1  hsync delayed to align with RGB
vsync_out  out  1  vsync delayed to align with RGB

Behaviour:
- Reset (async, active-high): red/green/blue = 0, hsync_out = vsync_out = 1, pipeline regs = 0, shadow regs = 0, flash counters = 0, blink counter = 0, blink phase = ON.
- Pipeline: 2 pix_en ticks. Stage 1 registers x, y, active and the syncs. Stage 2 computes colour from the stage-1 values and registers RGB plus the syncs. Stage 2 draws black whenever stage-1 active = 0. When pix_en = 0, every register except hit pending holds.
- Frame start (FS): a pix_en tick with x = 0 and y = 0. At FS:
  - winner, block_top, block_bot and res_top load into shadow registers at the same edge stage 1 captures pixel (0,0). Pixel (0,0) and the rest of that frame use the new values.
  - Inputs that change mid-frame have no effect until the next FS.
- Hit flash: hit_pulse[i] sets pending[i] on any clk, whether or not pix_en is high. At FS:
  - pending[i] = 1 loads flash_cnt[i] = HIT_FLASH_FRAMES and clears pending[i].
  - Otherwise a non-zero flash_cnt[i] decrements.
  - A pulse on the FS edge itself is kept in pending and is taken at the next FS.
  - A retrigger while flashing reloads the counter.
- Play screen (shadow winner = 0), first match wins:
  1. Lane i block: x in [LANE_X0+i*LANE_PITCH, +LANE_W) and y in [top_i, bot_i). Lower i has priority. If top_i >= bot_i, the lane draws no block.
  2. Lane i hit bar: same x range, y in [HIT_Y0, HIT_Y1). Colour is FLASH_RGB when flash_cnt[i] != 0, else HIT_RGB.
  3. Score bar i: x in [RES_X0+i*RES_PITCH, +RES_W) and res_top_i <= y < V_ACTIVE, in LANE_RGB[i].
  4. Otherwise black.
- Win screen (shadow winner = k, 1 <= k <= NUM_LANES): the whole active area is LANE_RGB[k-1] during the ON phase and black during OFF. Draw (winner > NUM_LANES) uses DRAW_RGB with the same blinking.
- Blink:
  - The counter counts FS events while shadow winner != 0. Each time it reaches BLINK_FRAMES-1 it wraps to 0 and toggles the phase.
  - On FS where shadow winner changes 0 -> non-zero, the counter goes to 0 and the phase to ON.
  - While winner = 0, the counter is held at 0 and the phase at ON.
  - BLINK_FRAMES = 0 gives a permanent ON phase.
- Arithmetic: x comparisons are 12-bit unsigned and y comparisons 11-bit unsigned, so edge sums do not wrap. Lanes whose left edge is >= H_ACTIVE never draw.

Test Plan:
- Reset mid-frame with the pipeline full -> RGB = 0 and syncs = 1 immediately. After release, the first valid pixel appears 2 pix_en ticks later.
- Play, block_top0 = 100, block_bot0 = 200, pixel (170,100) with active = 1 -> RGB = F,0,0 two ticks later. Pixels (469,199) red, (470,150) black, (170,200) black.
- block_top0 changed to 300 at y = 400 -> rows 401..719 of that frame still use 100. The next frame draws from 300.
- hit_pulse[1] once before FS -> hit bar at (810,630) is FFF for exactly 6 frames, then 00F. A second pulse in frame 3 extends it to 6 frames from the reload.
- winner 0 -> 2 at mid-frame -> the change takes effect at the next FS. The full screen is 0F0 for 30 frames, black for 30, then green again. winner = 3 gives the same pattern in FF0.
- active = 0 with winner = 1 -> RGB = 0. hsync_out/vsync_out equal hsync_in/vsync_in delayed by exactly 2 pix_en ticks, and hold while pix_en = 0.
